// File: rtl/mem_bus_arbiter.sv
// Two-master (I-cache / D-cache) arbiter onto a single memory port.
// Round-robin on ties, one outstanding read, response timeout with error reply.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              i_resp_valid,
  output logic [31:0]       i_resp_rdata,
  output logic              i_resp_error,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_wen,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  output logic              d_resp_valid,
  output logic [31:0]       d_resp_rdata,
  output logic              d_resp_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  input  logic              mem_resp_error
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RESP, ERR_RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 1 = D was granted last
  logic             owner_q, owner_d;            // 1 = D owns the outstanding read
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic grant_d, any_valid, in_idle, in_wait, in_err, xfer, resp_any;

  always_comb begin
    any_valid = i_req_valid | d_req_valid;
    grant_d   = d_req_valid & (~i_req_valid | ~last_grant_q);
    // rst_n gates the handshake so nothing can be offered while reset is held
    in_idle   = rst_n & (state_q == IDLE);
    in_wait   = (state_q == WAIT_RESP);
    in_err    = (state_q == ERR_RESP);

    mem_req_valid = in_idle & any_valid;
    mem_req_addr  = grant_d ? d_req_addr  : i_req_addr;
    mem_req_wen   = grant_d ? d_req_wen   : i_req_wen;
    mem_req_wdata = grant_d ? d_req_wdata : i_req_wdata;

    i_req_ready = in_idle & any_valid & ~grant_d & mem_req_ready;
    d_req_ready = in_idle & grant_d & mem_req_ready;
    xfer        = mem_req_valid & mem_req_ready;

    resp_any     = (in_wait & mem_resp_valid) | in_err;
    i_resp_valid = resp_any & ~owner_q;
    d_resp_valid = resp_any & owner_q;
    i_resp_rdata = (in_wait & ~owner_q) ? mem_resp_rdata : 32'h0;
    d_resp_rdata = (in_wait &  owner_q) ? mem_resp_rdata : 32'h0;
    i_resp_error = ~owner_q & ((in_wait & mem_resp_valid & mem_resp_error) | in_err);
    d_resp_error =  owner_q & ((in_wait & mem_resp_valid & mem_resp_error) | in_err);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          last_grant_d = grant_d;
          if (!mem_req_wen) begin
            owner_d = grant_d;
            cnt_d   = '0;
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        // a response arriving on the timeout cycle still wins
        if (mem_resp_valid)        state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = ERR_RESP;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ERR_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 0, i_req_wen = 0, d_req_valid = 0, d_req_wen = 0;
  logic [31:0] i_req_addr = 0, i_req_wdata = 0, d_req_addr = 0, d_req_wdata = 0;
  logic        i_req_ready, d_req_ready;
  logic        i_resp_valid, i_resp_error, d_resp_valid, d_resp_error;
  logic [31:0] i_resp_rdata, d_resp_rdata;
  logic        mem_req_valid, mem_req_wen;
  logic        mem_req_ready = 0, mem_resp_valid = 0, mem_resp_error = 0;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = 0;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_resp_error(i_resp_error),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wen(d_req_wen),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_error(d_resp_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_error(mem_resp_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h time=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a read is "outstanding" for some number of waited cycles;
  // after TMO silent cycles the owner gets one error reply.
  bit m_pending = 0;
  bit m_owner_d = 0;
  int m_waited  = 0;
  bit m_err_now = 0;
  bit m_prefer_d = 0;

  function automatic bit pick_d();
    return d_req_valid && (!i_req_valid || m_prefer_d);
  endfunction

  always @(negedge rst_n) begin
    m_pending = 0; m_err_now = 0; m_prefer_d = 0; m_waited = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_err_now) m_err_now = 0;
      else if (m_pending) begin
        if (mem_resp_valid) m_pending = 0;
        else begin
          m_waited++;
          if (m_waited == TMO) begin
            m_pending = 0;
            m_err_now = 1;
          end
        end
      end else if ((i_req_valid || d_req_valid) && mem_req_ready) begin
        bit pd;
        bit wen;
        pd  = pick_d();
        wen = pd ? d_req_wen : i_req_wen;
        m_prefer_d = !pd;
        if (!wen) begin
          m_pending = 1; m_owner_d = pd; m_waited = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit idle, any, pd, rv, e_mv;
    any  = i_req_valid || d_req_valid;
    pd   = pick_d();
    idle = rst_n && !m_pending && !m_err_now;
    e_mv = idle && any;
    rv   = (m_pending && mem_resp_valid) || m_err_now;
    chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e_mv});
    if (e_mv) begin
      chk("mem_req_addr",  mem_req_addr,  pd ? d_req_addr : i_req_addr);
      chk("mem_req_wen",   {31'b0, mem_req_wen}, {31'b0, pd ? d_req_wen : i_req_wen});
      chk("mem_req_wdata", mem_req_wdata, pd ? d_req_wdata : i_req_wdata);
    end
    chk("i_req_ready", {31'b0, i_req_ready}, {31'b0, e_mv && !pd && mem_req_ready});
    chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, e_mv && pd && mem_req_ready});
    chk("i_resp_valid", {31'b0, i_resp_valid}, {31'b0, rv && !m_owner_d});
    chk("d_resp_valid", {31'b0, d_resp_valid}, {31'b0, rv && m_owner_d});
    if (rv) begin
      if (m_owner_d) begin
        chk("d_resp_rdata", d_resp_rdata, m_err_now ? 32'h0 : mem_resp_rdata);
        chk("d_resp_error", {31'b0, d_resp_error}, {31'b0, m_err_now || mem_resp_error});
      end else begin
        chk("i_resp_rdata", i_resp_rdata, m_err_now ? 32'h0 : mem_resp_rdata);
        chk("i_resp_error", {31'b0, i_resp_error}, {31'b0, m_err_now || mem_resp_error});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_req_valid = 0; d_req_valid = 0; i_req_wen = 0; d_req_wen = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_error = 0; mem_resp_rdata = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    step(1);
    rst_n = 1;
  endtask

  initial begin
    int n;
    quiet();
    #1;
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_i_resp_valid", {31'b0, i_resp_valid}, 32'h0);
    step(2);
    rst_n = 1;
    step(1);

    // single I read, response 3 cycles after the transfer
    i_req_valid = 1; i_req_addr = 32'h100; mem_req_ready = 1;
    #1 chk("rd_i_ready", {31'b0, i_req_ready}, 32'h1);
    chk("rd_addr", mem_req_addr, 32'h100);
    step(1);
    quiet();
    step(2);
    mem_resp_valid = 1; mem_resp_rdata = 32'hDEADBEEF;
    #1 chk("rd_resp_valid", {31'b0, i_resp_valid}, 32'h1);
    chk("rd_resp_rdata", i_resp_rdata, 32'hDEADBEEF);
    chk("rd_d_quiet", {31'b0, d_resp_valid}, 32'h0);
    step(1);
    quiet();
    step(2);

    // tie from reset: grants alternate I, D, I, D
    pulse_reset();
    i_req_valid = 1; d_req_valid = 1; mem_req_ready = 1;
    mem_resp_valid = 1; mem_resp_rdata = 32'h0000_1111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("tie_grant_i", {31'b0, i_req_ready}, {31'b0, k % 2 == 0});
      chk("tie_grant_d", {31'b0, d_req_ready}, {31'b0, k % 2 == 1});
      step(1);
      chk("tie_resp_d", {31'b0, d_resp_valid}, {31'b0, k % 2 == 1});
      chk("tie_resp_i", {31'b0, i_resp_valid}, {31'b0, k % 2 == 0});
      step(1);
    end
    quiet();
    step(2);

    // D write passes through, then I read granted on the very next cycle
    d_req_valid = 1; d_req_wen = 1; d_req_addr = 32'h200; d_req_wdata = 32'h12345678;
    mem_req_ready = 1;
    #1 chk("wr_wen", {31'b0, mem_req_wen}, 32'h1);
    chk("wr_addr", mem_req_addr, 32'h200);
    chk("wr_wdata", mem_req_wdata, 32'h12345678);
    step(1);
    d_req_valid = 0; d_req_wen = 0;
    i_req_valid = 1; i_req_addr = 32'h204;
    #1 chk("wr_then_i_ready", {31'b0, i_req_ready}, 32'h1);
    step(1);
    quiet();
    mem_resp_valid = 1;
    step(1);
    quiet();
    step(1);

    // timeout: D read never answered
    d_req_valid = 1; d_req_addr = 32'h300; mem_req_ready = 1;
    step(1);
    quiet();
    n = 0;
    while (!d_resp_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_error", {31'b0, d_resp_error}, 32'h1);
    chk("tmo_rdata", d_resp_rdata, 32'h0);
    step(1);
    mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0BAD0;
    #1 chk("tmo_late_dropped", {31'b0, d_resp_valid}, 32'h0);
    step(1);
    quiet();

    // back-pressure: D held valid while memory stalls
    d_req_valid = 1; d_req_addr = 32'h400;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_d_ready", {31'b0, d_req_ready}, 32'h0);
      step(1);
    end
    mem_req_ready = 1;
    #1 chk("bp_d_ready_go", {31'b0, d_req_ready}, 32'h1);
    step(1);
    quiet();
    mem_resp_valid = 1;
    step(1);
    quiet();

    // reset in the middle of a read
    i_req_valid = 1; i_req_addr = 32'h500; mem_req_ready = 1;
    step(1);
    mem_resp_valid = 1;
    rst_n = 0;
    #1 chk("rstmid_mem_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rstmid_i_ready", {31'b0, i_req_ready}, 32'h0);
    chk("rstmid_i_resp", {31'b0, i_resp_valid}, 32'h0);
    step(1);
    rst_n = 1;
    i_req_valid = 0;
    #1 chk("rstmid_stray", {31'b0, i_resp_valid}, 32'h0);
    step(1);
    quiet();
    i_req_valid = 1; i_req_addr = 32'h600; mem_req_ready = 1;
    #1 chk("rstmid_next_ready", {31'b0, i_req_ready}, 32'h1);
    step(1);
    quiet();
    mem_resp_valid = 1; mem_resp_rdata = 32'hCAFEF00D;
    #1 chk("rstmid_next_resp", i_resp_rdata, 32'hCAFEF00D);
    step(1);
    quiet();

    // random traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      i_req_valid    = $urandom_range(0, 1);
      d_req_valid    = $urandom_range(0, 1);
      i_req_wen      = ($urandom_range(0, 2) == 0);
      d_req_wen      = ($urandom_range(0, 2) == 0);
      i_req_addr     = $urandom;
      d_req_addr     = $urandom;
      i_req_wdata    = $urandom;
      d_req_wdata    = $urandom;
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = ($urandom_range(0, 3) == 0);
      mem_resp_rdata = $urandom;
      mem_resp_error = ($urandom_range(0, 7) == 0);
      rst_n          = ($urandom_range(0, 399) != 0);
      step(1);
    end
    rst_n = 1;
    quiet();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
